serial_tx_arbiter: RTL and testbench

Shares the single UART transmit path of the Serial block between N byte-stream requesters, e.g. the string transmitter and a memory-dump streamer. Arbitration is message-level: a requester keeps the transmitter until its byte flagged "last" has been sent. The block drives Serial's send strobe and send data, and paces itself on Serial's busy flag. It sits between the requesters and the Serial instance in the top level.

---
 rtl/serial_tx_arbiter.sv | 250 +++++++++++++++++++++++++
 tb/tb_serial_tx_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx_arbiter.sv
// Purpose : shares one UART transmit path between N byte-stream requesters.
//           A requester keeps the grant until its "last" byte has been sent.
// Latency : 1 cycle arbitration, then one byte per Serial busy period (>= 3 cycles/byte).
// Backpr. : o_ready pulses once per consumed byte; a send is only issued with i_txd_busy low.
//
// Ports:
//   i_Clk, i_Rst_n          clock, asynchronous active-low reset
//   i_valid/i_data/i_last   per-requester byte stream (byte k on i_data[8k+7:8k])
//   o_ready                 one-cycle consume pulse to the grantee
//   i_txd_busy              Serial transmitter busy
//   o_send/o_send_data      send strobe and byte to Serial
//   o_grant/o_active        one-hot owner and message-in-progress flag
//   o_drop                  pulse when a stalled grantee loses its grant (HOLD_TIMEOUT)
//   o_byte_count            bytes sent since reset, wrapping
//
// Build option: define TXARB_FIXED_PRIO_EN for fixed priority (lowest index wins);
// otherwise arbitration is round-robin starting from the index after the last owner.

module serial_tx_arbiter #(
   parameter int N            = 2,
   parameter int BUSY_TIMEOUT = 16,
   parameter int HOLD_TIMEOUT = 0
) (
   input  logic           i_Clk,
   input  logic           i_Rst_n,
   input  logic [N-1:0]   i_valid,
   input  logic [8*N-1:0] i_data,
   input  logic [N-1:0]   i_last,
   output logic [N-1:0]   o_ready,
   input  logic           i_txd_busy,
   output logic           o_send,
   output logic [7:0]     o_send_data,
   output logic [N-1:0]   o_grant,
   output logic           o_active,
   output logic           o_drop,
   output logic [15:0]    o_byte_count
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;
   // Timers count 0 .. TIMEOUT-1 and are cleared outside their state.
   localparam int BW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
   localparam int HW = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;
   localparam logic [BW-1:0] BUSY_LAST = BW'((BUSY_TIMEOUT > 0) ? BUSY_TIMEOUT - 1 : 0);
   localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_TIMEOUT > 0) ? HOLD_TIMEOUT - 1 : 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_WAIT_HI,
      S_WAIT_LO,
      S_HOLD
   } state_t;

   state_t         state;
   state_t         state_nxt;

   logic [N-1:0]   grant_q;
   logic [IW-1:0]  grant_idx;
   logic           active_q;
   logic           last_q;
   logic [7:0]     send_data_q;
   logic           drop_q;
   logic [15:0]    byte_cnt_q;
   logic [BW-1:0]  busy_cnt;
   logic [HW-1:0]  hold_cnt;

   logic           arb_win;
   logic           release_grant;
   logic           expire;

   logic [IW-1:0]  win_idx;
   logic [N-1:0]   win_oh;
   logic           grant_vld;
   logic           grant_last;
   logic [IW-1:0]  src_idx;
   logic [7:0]     src_data;

   //------------------------------------------------------------------
   // Winner selection
   //------------------------------------------------------------------
`ifdef TXARB_FIXED_PRIO_EN
   always_comb begin
      win_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (i_valid[i]) win_idx = IW'(i);
      end
   end
`else
   logic [IW-1:0]  ptr_q;
   logic [IW-1:0]  ptr_nxt;
   logic [2*N-1:0] valid_dbl;
   logic [2*N-1:0] valid_rot;
   logic           found;
   int             sum;

   // Rotating a doubled copy puts requester (ptr+i) mod N at bit i, so a
   // plain lowest-set-bit scan over the low N bits gives round-robin order.
   always_comb begin
      valid_dbl = {i_valid, i_valid};
      valid_rot = valid_dbl >> ptr_q;
      win_idx   = '0;
      found     = 1'b0;
      sum       = 0;
      for (int i = 0; i < N; i++) begin
         if (valid_rot[i] && !found) begin
            found = 1'b1;
            sum   = int'(ptr_q) + i;
            if (sum >= N) sum = sum - N;
            win_idx = IW'(sum);
         end
      end
   end

   // Next pointer is the slot after the releasing owner; stays 0 when N = 1.
   always_comb begin
      ptr_nxt = '0;
      if (int'(grant_idx) + 1 < N) ptr_nxt = grant_idx + IW'(1);
   end

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         ptr_q <= '0;
      end else if (release_grant) begin
         ptr_q <= ptr_nxt;
      end
   end
`endif

   always_comb begin
      win_oh = '0;
      for (int k = 0; k < N; k++) begin
         win_oh[k] = (win_idx == IW'(k));
      end
   end

   //------------------------------------------------------------------
   // Grantee view of the request inputs
   //------------------------------------------------------------------
   assign grant_vld = |(i_valid & grant_q);
   // From IDLE the byte to load belongs to the fresh winner, otherwise to the owner.
   assign src_idx   = (state == S_IDLE) ? win_idx : grant_idx;

   always_comb begin
      src_data   = '0;
      grant_last = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (src_idx == IW'(k))   src_data   = i_data[8*k +: 8];
         if (grant_idx == IW'(k)) grant_last = i_last[k];
      end
   end

   //------------------------------------------------------------------
   // FSM
   //------------------------------------------------------------------
   always_comb begin
      state_nxt     = state;
      arb_win       = 1'b0;
      release_grant = 1'b0;
      expire        = 1'b0;
      case (state)
         S_IDLE: begin
            if ((|i_valid) && !i_txd_busy) begin
               arb_win   = 1'b1;
               state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            state_nxt = S_WAIT_HI;
         end
         S_WAIT_HI: begin
            // A Serial that never raises busy still gets the byte counted as taken.
            if (i_txd_busy || (busy_cnt == BUSY_LAST)) state_nxt = S_WAIT_LO;
         end
         S_WAIT_LO: begin
            if (!i_txd_busy) begin
               if (last_q) begin
                  release_grant = 1'b1;
                  state_nxt     = S_IDLE;
               end else if (grant_vld) begin
                  state_nxt = S_LOAD;
               end else begin
                  state_nxt = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (grant_vld) begin
               state_nxt = S_LOAD;
            end else if ((HOLD_TIMEOUT != 0) && (hold_cnt == HOLD_LAST)) begin
               release_grant = 1'b1;
               expire        = 1'b1;
               state_nxt     = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state       <= S_IDLE;
         grant_q     <= '0;
         grant_idx   <= '0;
         active_q    <= 1'b0;
         last_q      <= 1'b0;
         send_data_q <= '0;
         drop_q      <= 1'b0;
         byte_cnt_q  <= '0;
         busy_cnt    <= '0;
         hold_cnt    <= '0;
      end else begin
         state  <= state_nxt;
         drop_q <= expire;

         if (arb_win) begin
            grant_q   <= win_oh;
            grant_idx <= win_idx;
            active_q  <= 1'b1;
         end else if (release_grant) begin
            grant_q  <= '0;
            active_q <= 1'b0;
         end

         // Byte is captured on entry to LOAD and held until the next load.
         if (state_nxt == S_LOAD) send_data_q <= src_data;

         if (state == S_LOAD) begin
            last_q     <= grant_last;
            byte_cnt_q <= byte_cnt_q + 16'd1;
         end

         busy_cnt <= (state == S_WAIT_HI) ? busy_cnt + BW'(1) : '0;
         hold_cnt <= (state == S_HOLD)    ? hold_cnt + HW'(1) : '0;
      end
   end

   //------------------------------------------------------------------
   // Outputs
   //------------------------------------------------------------------
   assign o_send       = (state == S_LOAD);
   assign o_ready      = {N{o_send}} & grant_q;
   assign o_send_data  = send_data_q;
   assign o_grant      = grant_q;
   assign o_active     = active_q;
   assign o_drop       = drop_q;
   assign o_byte_count = byte_cnt_q;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Bench for serial_tx_arbiter: directed messages from two requesters against
// a Serial model that stays busy 10 cycles after each strobe (or never).
// Expected sends are queued at stimulus time and popped by a monitor.

module tb_serial_tx_arbiter;

   localparam int N = 2;

   logic           i_Clk = 1'b0;
   logic           i_Rst_n = 1'b0;
   logic [N-1:0]   i_valid;
   logic [8*N-1:0] i_data;
   logic [N-1:0]   i_last;
   logic [N-1:0]   o_ready;
   logic           i_txd_busy;
   logic           o_send;
   logic [7:0]     o_send_data;
   logic [N-1:0]   o_grant;
   logic           o_active;
   logic           o_drop;
   logic [15:0]    o_byte_count;

   serial_tx_arbiter #(.N(N), .BUSY_TIMEOUT(16), .HOLD_TIMEOUT(20)) dut (
      .i_Clk        (i_Clk),
      .i_Rst_n      (i_Rst_n),
      .i_valid      (i_valid),
      .i_data       (i_data),
      .i_last       (i_last),
      .o_ready      (o_ready),
      .i_txd_busy   (i_txd_busy),
      .o_send       (o_send),
      .o_send_data  (o_send_data),
      .o_grant      (o_grant),
      .o_active     (o_active),
      .o_drop       (o_drop),
      .o_byte_count (o_byte_count)
   );

   always #5 i_Clk = ~i_Clk;

   typedef struct {
      logic [7:0] d;
      logic       last;
      int         gap;
   } item_t;

   typedef struct {
      int         g;
      logic [7:0] d;
   } exp_t;

   item_t q0[$];
   item_t q1[$];
   exp_t  sb[$];
   int    send_cyc[$];
   int    drop_cyc[$];

   logic       v0 = 1'b0, v1 = 1'b0, l0 = 1'b0, l1 = 1'b0;
   logic [7:0] d0 = '0, d1 = '0;
   assign i_valid = {v1, v0};
   assign i_last  = {l1, l0};
   assign i_data  = {d1, d0};

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int rdy0 = 0;
   int exp_bytes = 0;

   // Serial model: busy for 10 cycles after each strobe; not reset by i_Rst_n.
   logic       busy_en = 1'b1;
   logic [4:0] bcnt = '0;
   always @(posedge i_Clk) begin
      if (busy_en && o_send) bcnt <= 5'd10;
      else if (bcnt != 0)    bcnt <= bcnt - 5'd1;
   end
   assign i_txd_busy = (bcnt != 0);

   always @(posedge i_Clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic expect_send(input int g, input logic [7:0] d);
      exp_t e;
      e.g = g;
      e.d = d;
      sb.push_back(e);
      exp_bytes++;
   endtask

   task automatic push0(input logic [7:0] d, input logic last, input int gap);
      item_t it;
      it.d = d; it.last = last; it.gap = gap;
      q0.push_back(it);
   endtask

   task automatic push1(input logic [7:0] d, input logic last, input int gap);
      item_t it;
      it.d = d; it.last = last; it.gap = gap;
      q1.push_back(it);
   endtask

   function automatic int send_gap(input int i);
      if (send_cyc.size() > i + 1) return send_cyc[i+1] - send_cyc[i];
      return -1;
   endfunction

   task automatic wait_idle(input string nm, input int budget);
      bit done;
      done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         @(negedge i_Clk);
         done = (q0.size() == 0) && (q1.size() == 0) && !v0 && !v1 &&
                !o_active && !i_txd_busy && (sb.size() == 0);
      end
      check(nm, {31'd0, done}, 32'd1);
   endtask

   task automatic wait_sends(input string nm, input int n, input int budget);
      bit done;
      done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         @(negedge i_Clk);
         done = (send_cyc.size() >= n);
      end
      check(nm, {31'd0, done}, 32'd1);
   endtask

   // Requester driver: presents the head item, advances the cycle after o_ready.
   initial begin
      logic [N-1:0] rs;
      forever begin
         @(negedge i_Clk);
         rs = o_ready;
         @(posedge i_Clk);
         #1;
         if (!i_Rst_n) begin
            q0.delete(); q1.delete();
            v0 = 1'b0; v1 = 1'b0;
         end else begin
            if (v0 && rs[0]) begin q0.delete(0); v0 = 1'b0; end
            if (!v0 && q0.size() > 0) begin
               if (q0[0].gap > 0) q0[0].gap = q0[0].gap - 1;
               else begin v0 = 1'b1; d0 = q0[0].d; l0 = q0[0].last; end
            end
            if (v1 && rs[1]) begin q1.delete(0); v1 = 1'b0; end
            if (!v1 && q1.size() > 0) begin
               if (q1[0].gap > 0) q1[0].gap = q1[0].gap - 1;
               else begin v1 = 1'b1; d1 = q1[0].d; l1 = q1[0].last; end
            end
         end
      end
   end

   // Monitor: every strobe is matched against the head of the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge i_Clk);
         if (i_Rst_n) begin
            if (o_drop) drop_cyc.push_back(cyc);
            if (o_ready[0]) rdy0++;
            if (o_send) begin
               send_cyc.push_back(cyc);
               check("send_while_busy", {31'd0, i_txd_busy}, 32'd0);
               if (sb.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL unexpected_send: got data %0h grant %0b, expected no send", o_send_data, o_grant);
               end else begin
                  e = sb.pop_front();
                  check("send_data", {24'd0, o_send_data}, {24'd0, e.d});
                  check("send_grant", {30'd0, o_grant}, 32'd1 << e.g);
                  check("send_ready", {30'd0, o_ready}, 32'd1 << e.g);
               end
            end else if (o_ready != '0) begin
               check("stray_ready", {30'd0, o_ready}, 32'd0);
            end
         end
      end
   end

   initial begin
      int base;
      int dbase;
      int rbase;

      // Reset state
      repeat (3) @(negedge i_Clk);
      check("rst_send",   {31'd0, o_send}, 32'd0);
      check("rst_data",   {24'd0, o_send_data}, 32'd0);
      check("rst_grant",  {30'd0, o_grant}, 32'd0);
      check("rst_ready",  {30'd0, o_ready}, 32'd0);
      check("rst_active", {31'd0, o_active}, 32'd0);
      check("rst_drop",   {31'd0, o_drop}, 32'd0);
      check("rst_count",  {16'd0, o_byte_count}, 32'd0);
      i_Rst_n = 1'b1;
      @(negedge i_Clk);

      // Both requesters valid together, 1-byte messages
      push0(8'h10, 1'b1, 0); push0(8'h11, 1'b1, 0);
      push1(8'h20, 1'b1, 0); push1(8'h21, 1'b1, 0);
`ifdef TXARB_FIXED_PRIO_EN
      expect_send(0, 8'h10); expect_send(0, 8'h11);
      expect_send(1, 8'h20); expect_send(1, 8'h21);
`else
      expect_send(0, 8'h10); expect_send(1, 8'h20);
      expect_send(0, 8'h11); expect_send(1, 8'h21);
`endif
      wait_idle("arb_done", 400);
      check("arb_count", {16'd0, o_byte_count}, exp_bytes);

      // Req0 three-byte message
      base  = send_cyc.size();
      rbase = rdy0;
      push0(8'h41, 1'b0, 0); push0(8'h42, 1'b0, 0); push0(8'h43, 1'b1, 0);
      expect_send(0, 8'h41); expect_send(0, 8'h42); expect_send(0, 8'h43);
      wait_idle("msg3_done", 400);
      check("msg3_count",  {16'd0, o_byte_count}, exp_bytes);
      check("msg3_ready0", rdy0 - rbase, 3);
      check("msg3_grant",  {30'd0, o_grant}, 32'd0);
      check("msg3_active", {31'd0, o_active}, 32'd0);
      check("msg3_pace",   send_gap(base), 12);

      // Req0 appears in the middle of req1's message
      push1(8'h51, 1'b0, 0); push1(8'h52, 1'b0, 0); push1(8'h53, 1'b1, 0);
      push0(8'h61, 1'b1, 5);
      expect_send(1, 8'h51); expect_send(1, 8'h52); expect_send(1, 8'h53);
      expect_send(0, 8'h61);
      wait_idle("lock_done", 400);

      // Serial never raises busy: WAIT_HI times out after 16 cycles
      busy_en = 1'b0;
      base = send_cyc.size();
      push0(8'h71, 1'b0, 0); push0(8'h72, 1'b1, 0);
      expect_send(0, 8'h71); expect_send(0, 8'h72);
      wait_idle("nobusy_done", 400);
      check("nobusy_pace", send_gap(base), 18);
      busy_en = 1'b1;

      // Grantee stalls after a non-last byte; grant revoked 20 cycles into HOLD
      base  = send_cyc.size();
      dbase = drop_cyc.size();
      push0(8'h81, 1'b0, 0); push0(8'h82, 1'b1, 40);
      push1(8'h91, 1'b1, 3);
      expect_send(0, 8'h81); expect_send(1, 8'h91); expect_send(0, 8'h82);
      wait_idle("hold_done", 400);
      check("drop_pulses", drop_cyc.size() - dbase, 1);
      if (drop_cyc.size() > dbase && send_cyc.size() > base)
         check("drop_time", drop_cyc[dbase] - send_cyc[base], 32);

      // Reset in WAIT_LO, pointer left at 1 beforehand
      push0(8'hA0, 1'b1, 0);
      expect_send(0, 8'hA0);
      wait_idle("pre_rst_done", 400);
      base = send_cyc.size();
      push1(8'hB0, 1'b0, 0); push1(8'hB1, 1'b1, 0);
      expect_send(1, 8'hB0);
      wait_sends("b0_sent", base + 1, 100);
      repeat (3) @(negedge i_Clk);
      #2;
      i_Rst_n = 1'b0;
      #1;
      check("arst_send",   {31'd0, o_send}, 32'd0);
      check("arst_grant",  {30'd0, o_grant}, 32'd0);
      check("arst_active", {31'd0, o_active}, 32'd0);
      check("arst_data",   {24'd0, o_send_data}, 32'd0);
      check("arst_count",  {16'd0, o_byte_count}, 32'd0);
      repeat (2) @(negedge i_Clk);
      i_Rst_n   = 1'b1;
      exp_bytes = 0;
      push0(8'hC0, 1'b1, 0);
      push1(8'hC1, 1'b1, 0);
      expect_send(0, 8'hC0); expect_send(1, 8'hC1);
      wait_idle("post_rst_done", 400);
      check("post_rst_count", {16'd0, o_byte_count}, exp_bytes);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
